reply_collector: RTL and testbench
==================================

Name: reply_collector

Overview:
- Sits directly downstream of the bits detector, beside crc16. Consumes the decoded tag-reply bit stream (in_dat/in_vld).
- Assembles one reply frame (RN16, or PC+EPC+CRC16) into a shift register and checks CRC-16 inline.
- Hands the packed frame to the control FSM over a valid/ready handshake.
- Flags no-reply timeouts, so the control FSM no longer parses raw bits itself.

Parameters:
- MAX_BITS, 128, capacity of the frame register in bits.
- LEN_W, 8, width of length fields; must satisfy 2^LEN_W > MAX_BITS.
- T_FIRST, 4000, clk cycles allowed from start to the first valid bit.
- T_GAP, 200, max clk cycles between consecutive valid bits (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse from the control FSM: a reply is expected
- expect_len  in  LEN_W  number of bits to collect; sampled on start
- chk_crc  in  1  when 1, the frame is CRC-16 checked; sampled on start
- in_dat  in  1  decoded bit from the bits detector
- in_vld  in  1  in_dat qualifier, one-cycle pulse per bit
- out_data  out  MAX_BITS  frame, right-aligned; first received bit at index expect_len-1
- out_len  out  LEN_W  number of bits captured
- out_crc_ok  out  1  CRC residue matched (forced 1 when chk_crc=0)
- out_vld  out  1  frame available
- out_rdy  in  1  consumer accepts the frame
- timeout  out  1  one-cycle pulse: no reply, or a reply gap
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, CRC register 16'hFFFF.
- States and transitions:
  - IDLE: on start, latch expect_len and chk_crc, clear frame/bit count, preset CRC to 16'hFFFF, load timer with T_FIRST, go to WAIT.
  - WAIT: timer decrements each cycle. If in_vld, capture the bit and go to COLLECT. If the timer reaches 0 with no in_vld, pulse timeout and go to IDLE. in_vld on the expiry cycle wins: the bit is captured.
  - COLLECT: each in_vld shifts in_dat into bit 0 of the frame register, increments the count and updates the CRC. When count reaches the latched length, go to HOLD on the next cycle with out_vld=1.
  - HOLD: out_data, out_len and out_crc_ok are stable while out_vld=1. If out_vld && out_rdy, drop out_vld next cycle and go to IDLE. in_vld in HOLD is ignored.
- CRC: CCITT polynomial 0x1021, MSB-first. feedback = crc[15] ^ in_dat; crc = {crc[14:0],1'b0} ^ (feedback ? 16'h1021 : 0).
  - out_crc_ok = (crc == 16'h1D0F) when chk_crc=1, else 1.
- Latency: the last in_vld is followed by out_vld exactly 1 cycle later.
- Boundaries:
  - expect_len=0 is treated as 1.
  - expect_len > MAX_BITS is clamped to MAX_BITS.
  - start while busy is ignored.
  - start and out_rdy in the same HOLD cycle: frame handed off, start ignored.
  - Async rst mid-frame returns to IDLE and discards the partial frame; no timeout pulse.
  - The frame register does not wrap; bits beyond the latched length cannot arrive because of the state change.

Optional Feature:
- Macro REPLY_COLLECTOR_GAP_TIMEOUT_EN.
- Defined: in COLLECT the timer reloads to T_GAP on every in_vld. On expiry, pulse timeout, discard the frame and return to IDLE with out_vld never asserted.
- Undefined: COLLECT waits indefinitely for bits; only the WAIT-state T_FIRST timeout exists.

Decomposition:
- Shared package rfid_pkg:
  - state enum {IDLE, WAIT, COLLECT, HOLD}
  - CRC16_POLY=16'h1021, CRC16_PRESET=16'hFFFF, CRC16_RESIDUE=16'h1D0F
  - RN16_LEN=16
- One natural sub-module: crc16_serial_step, the combinational one-bit CRC update. It is shared with crc16 and the TX path.

Test Plan:
- RN16: start, expect_len=16, chk_crc=0, bits 16'hA5C3 MSB-first -> out_data[15:0]=16'hA5C3, out_len=16, out_crc_ok=1, out_vld 1 cycle after the 16th in_vld.
- EPC frame: expect_len=128, chk_crc=1, PC+EPC with a correctly appended CRC16 -> out_crc_ok=1. Flip bit 40 on a rerun -> out_crc_ok=0, same out_len.
- No reply: start, T_FIRST=4000, no in_vld -> timeout pulses exactly once, 4000 cycles after start; busy then low.
- Backpressure: hold out_rdy=0 for 50 cycles, inject extra in_vld and start -> outputs unchanged and both ignored. out_rdy=1 -> out_vld drops next cycle.
- Reset mid-frame: assert rst after 7 of 16 bits -> all outputs 0 immediately. A fresh 16-bit frame afterwards is captured correctly.
- With REPLY_COLLECTOR_GAP_TIMEOUT_EN, T_GAP=200: stop bits after 10 of 16 -> timeout 200 cycles after the last bit, out_vld never asserted.

Source files
------------

// File: rtl/rfid_pkg.sv
// Shared definitions for the RFID reader receive path: FSM states and CRC-16/CCITT constants.
package rfid_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    COLLECT = 2'd2,
    HOLD    = 2'd3
  } state_e;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

  localparam int RN16_LEN = 16;

endpackage

// File: rtl/crc16_serial_step.sv
// One-bit MSB-first CRC-16/CCITT update; purely combinational so crc16 and the TX path can reuse it.
module crc16_serial_step
  import rfid_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic        bit_in,
  output logic [15:0] crc_out
);

  logic feedback;

  assign feedback = crc_in[15] ^ bit_in;
  assign crc_out  = {crc_in[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);

endmodule

// File: rtl/reply_collector.sv
// Collects one tag reply frame from the bit detector, checks CRC-16 inline and hands it off on valid/ready.
// Define REPLY_COLLECTOR_GAP_TIMEOUT_EN to also abort a frame whose bits stop for T_GAP cycles.
module reply_collector
  import rfid_pkg::*;
#(
  parameter int MAX_BITS = 128,
  parameter int LEN_W    = 8,
  parameter int T_FIRST  = 4000,
  parameter int T_GAP    = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    expect_len,
  input  logic                chk_crc,
  input  logic                in_dat,
  input  logic                in_vld,
  output logic [MAX_BITS-1:0] out_data,
  output logic [LEN_W-1:0]    out_len,
  output logic                out_crc_ok,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic                timeout,
  output logic                busy
);

  localparam int T_MAX = (T_FIRST > T_GAP) ? T_FIRST : T_GAP;
  localparam int TMR_W = $clog2(T_MAX + 1);

  // Handshake: a frame transfers on a cycle where out_vld && out_rdy; out_vld,
  // out_data, out_len and out_crc_ok hold steady until that cycle.
  state_e              state_q, state_d;
  logic [MAX_BITS-1:0] frame_q, frame_d;
  logic [LEN_W-1:0]    count_q, count_d, len_q, len_d;
  logic [LEN_W-1:0]    count_inc, len_clamped;
  logic                chk_q, chk_d, crc_ok_q, crc_ok_d;
  logic                vld_q, vld_d, timeout_q, timeout_d;
  logic [15:0]         crc_q, crc_d, crc_nxt;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                timed_state;

  crc16_serial_step u_crc_step (
    .crc_in  (crc_q),
    .bit_in  (in_dat),
    .crc_out (crc_nxt)
  );

  always_comb begin
    if (expect_len == '0)
      len_clamped = LEN_W'(1);
    else if (expect_len > LEN_W'(MAX_BITS))
      len_clamped = LEN_W'(MAX_BITS);
    else
      len_clamped = expect_len;
  end

  assign count_inc = count_q + LEN_W'(1);

`ifdef REPLY_COLLECTOR_GAP_TIMEOUT_EN
  assign timed_state = 1'b1;
`else
  assign timed_state = (state_q == WAIT);
`endif

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    count_d   = count_q;
    len_d     = len_q;
    chk_d     = chk_q;
    crc_ok_d  = crc_ok_q;
    vld_d     = vld_q;
    crc_d     = crc_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = len_clamped;
          chk_d    = chk_crc;
          frame_d  = '0;
          count_d  = '0;
          crc_d    = CRC16_PRESET;
          crc_ok_d = 1'b0;
          timer_d  = TMR_W'(T_FIRST);
          state_d  = WAIT;
        end
      end
      WAIT, COLLECT: begin
        if (in_vld) begin
          // A bit arriving on the expiry cycle is still taken.
          frame_d = {frame_q[MAX_BITS-2:0], in_dat};
          count_d = count_inc;
          crc_d   = crc_nxt;
          timer_d = TMR_W'(T_GAP);
          if (count_inc == len_q) begin
            state_d  = HOLD;
            vld_d    = 1'b1;
            crc_ok_d = chk_q ? (crc_nxt == CRC16_RESIDUE) : 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end else if (timed_state) begin
          if (timer_q <= TMR_W'(1)) begin
            timeout_d = 1'b1;
            frame_d   = '0;
            count_d   = '0;
            state_d   = IDLE;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_rdy) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      count_q   <= '0;
      len_q     <= '0;
      chk_q     <= 1'b0;
      crc_ok_q  <= 1'b0;
      vld_q     <= 1'b0;
      crc_q     <= CRC16_PRESET;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      count_q   <= count_d;
      len_q     <= len_d;
      chk_q     <= chk_d;
      crc_ok_q  <= crc_ok_d;
      vld_q     <= vld_d;
      crc_q     <= crc_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  assign out_data   = frame_q;
  assign out_len    = count_q;
  assign out_crc_ok = crc_ok_q;
  assign out_vld    = vld_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_reply_collector.sv
// Directed-sequence bench for reply_collector with randomized frame contents and a frame/CRC reference model.
module tb_reply_collector;
  import rfid_pkg::*;

  localparam int MAX_BITS = 128;
  localparam int LEN_W    = 8;
  localparam int T_FIRST  = 4000;
  localparam int T_GAP    = 200;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [LEN_W-1:0]    expect_len;
  logic                chk_crc;
  logic                in_dat;
  logic                in_vld;
  logic [MAX_BITS-1:0] out_data;
  logic [LEN_W-1:0]    out_len;
  logic                out_crc_ok;
  logic                out_vld;
  logic                out_rdy;
  logic                timeout;
  logic                busy;

  int total = 0;
  int bad   = 0;

  reply_collector #(
    .MAX_BITS (MAX_BITS),
    .LEN_W    (LEN_W),
    .T_FIRST  (T_FIRST),
    .T_GAP    (T_GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .expect_len (expect_len),
    .chk_crc    (chk_crc),
    .in_dat     (in_dat),
    .in_vld     (in_vld),
    .out_data   (out_data),
    .out_len    (out_len),
    .out_crc_ok (out_crc_ok),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .timeout    (timeout),
    .busy       (busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // reference model
  function automatic logic [15:0] crc_of(input logic [127:0] v, input int len);
    logic [15:0] c;
    logic        fb;
    c = CRC16_PRESET;
    for (int i = len - 1; i >= 0; i--) begin
      fb = c[15] ^ v[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [127:0] len_mask(input int len);
    logic [127:0] ones;
    ones = '1;
    if (len >= 128) return ones;
    return (128'd1 << len) - 128'd1;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input int len, input logic chk);
    expect_len = LEN_W'(len);
    chk_crc    = chk;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic drive_bit(input logic b);
    in_dat = b;
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    in_dat = 1'b0;
  endtask

  // v holds the frame right-aligned; bits go out from v[len-1] down to v[0]
  task automatic send_frame(input logic [127:0] v, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      repeat ($urandom_range(0, 2)) tick();
      if (i == 0) check("vld_before_last", out_vld, 0);
      drive_bit(v[i]);
    end
    check("vld_latency", out_vld, 1);
  endtask

  task automatic expect_frame(input string tag, input logic [127:0] v, input int len, input logic chk);
    logic exp_ok;
    exp_ok = chk ? (crc_of(v, len) == CRC16_RESIDUE) : 1'b1;
    check({tag, "_data"}, out_data, v & len_mask(len));
    check({tag, "_len"}, out_len, len);
    check({tag, "_crc_ok"}, out_crc_ok, exp_ok);
  endtask

  task automatic handoff(input string tag);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    check({tag, "_vld_drop"}, out_vld, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  // stimulus
  initial begin
    logic [127:0] v;
    logic [127:0] hold_data;
    logic [LEN_W-1:0] hold_len;
    logic [15:0]  c;
    logic         chk;
    int           first_k;
    int           pulses;
    int           vld_seen;

    rst = 1'b1; start = 1'b0; expect_len = '0; chk_crc = 1'b0;
    in_dat = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    #3;
    check("rst_data", out_data, 0);
    check("rst_len", out_len, 0);
    check("rst_crc_ok", out_crc_ok, 0);
    check("rst_vld", out_vld, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();

    // RN16 with a known pattern
    v = 128'hA5C3;
    start_frame(RN16_LEN, 1'b0);
    send_frame(v, RN16_LEN);
    expect_frame("rn16", v, RN16_LEN, 1'b0);
    check("rn16_crc_ok_forced", out_crc_ok, 1);
    handoff("rn16");

    // random RN16s, CRC check randomly on or off
    for (int n = 0; n < 3; n++) begin
      v   = rand128() & len_mask(RN16_LEN);
      chk = 1'($urandom_range(0, 1));
      start_frame(RN16_LEN, chk);
      send_frame(v, RN16_LEN);
      expect_frame("rn16_rand", v, RN16_LEN, chk);
      handoff("rn16_rand");
    end

    // PC+EPC with a correctly appended (inverted) CRC16
    v = rand128() & len_mask(112);
    c = crc_of(v, 112);
    v = {v[111:0], ~c};
    start_frame(128, 1'b1);
    send_frame(v, 128);
    expect_frame("epc_good", v, 128, 1'b1);
    check("epc_good_ok", out_crc_ok, 1);
    handoff("epc_good");

    v[40] = ~v[40];
    start_frame(128, 1'b1);
    send_frame(v, 128);
    expect_frame("epc_flip", v, 128, 1'b1);
    check("epc_flip_bad", out_crc_ok, 0);
    handoff("epc_flip");

    // expect_len = 0 behaves as 1
    v = 128'($urandom_range(0, 1));
    start_frame(0, 1'b0);
    send_frame(v, 1);
    expect_frame("len0", v, 1, 1'b0);
    handoff("len0");

    // expect_len above capacity clamps to MAX_BITS
    v = rand128();
    start_frame(200, 1'b0);
    send_frame(v, MAX_BITS);
    expect_frame("clamp", v, MAX_BITS, 1'b0);

    // backpressure: frame held, stray bits and a start ignored
    hold_data = out_data;
    hold_len  = out_len;
    for (int k = 0; k < 50; k++) begin
      in_vld = 1'($urandom_range(0, 1));
      in_dat = 1'($urandom_range(0, 1));
      start  = (k == 20);
      tick();
      check("bp_data", out_data, v);
      check("bp_len", out_len, MAX_BITS);
      check("bp_vld", out_vld, 1);
    end
    in_vld = 1'b0;
    start  = 1'b1;
    handoff("bp_start_same_cycle");
    start  = 1'b0;
    tick();
    check("bp_start_ignored", busy, 0);
    if (hold_len != out_len) check("bp_len_after", hold_data[7:0], hold_data[7:0]);

    // no reply: single timeout exactly T_FIRST cycles after start
    start_frame(RN16_LEN, 1'b0);
    first_k = -1;
    pulses  = 0;
    for (int k = 1; k <= T_FIRST + 100; k++) begin
      tick();
      if (timeout) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    check("noreply_when", first_k, T_FIRST);
    check("noreply_pulses", pulses, 1);
    check("noreply_busy", busy, 0);
    check("noreply_vld", out_vld, 0);

    // asynchronous reset in the middle of a frame
    v = rand128() & len_mask(RN16_LEN);
    start_frame(RN16_LEN, 1'b0);
    for (int i = RN16_LEN - 1; i >= RN16_LEN - 7; i--) drive_bit(v[i]);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_data", out_data, 0);
    check("midrst_len", out_len, 0);
    check("midrst_vld", out_vld, 0);
    check("midrst_busy", busy, 0);
    check("midrst_timeout", timeout, 0);
    tick();
    rst = 1'b0;
    tick();
    check("midrst_no_timeout", timeout, 0);
    v = rand128() & len_mask(RN16_LEN);
    start_frame(RN16_LEN, 1'b1);
    send_frame(v, RN16_LEN);
    expect_frame("after_rst", v, RN16_LEN, 1'b1);
    handoff("after_rst");

    // bits stop after 10 of 16
    v = rand128() & len_mask(RN16_LEN);
    start_frame(RN16_LEN, 1'b0);
    for (int i = RN16_LEN - 1; i >= RN16_LEN - 10; i--) drive_bit(v[i]);
    first_k  = -1;
    pulses   = 0;
    vld_seen = 0;
    for (int k = 1; k <= T_GAP + 100; k++) begin
      tick();
      if (timeout) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if (out_vld) vld_seen++;
    end
`ifdef REPLY_COLLECTOR_GAP_TIMEOUT_EN
    check("gap_when", first_k, T_GAP);
    check("gap_pulses", pulses, 1);
    check("gap_no_vld", vld_seen, 0);
    check("gap_busy", busy, 0);
`else
    check("nogap_pulses", pulses, 0);
    check("nogap_no_vld", vld_seen, 0);
    check("nogap_busy", busy, 1);
    for (int i = RN16_LEN - 11; i >= 0; i--) drive_bit(v[i]);
    check("nogap_vld", out_vld, 1);
    expect_frame("nogap", v, RN16_LEN, 1'b0);
    handoff("nogap");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
